tetris_playfield: RTL



---
 rtl/tetris_pkg.sv | 46 ++++
 rtl/playfield_tick_gen.sv | 31 +++
 rtl/tetris_playfield.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared types and helpers for the Tetris playfield engine.
// Cell indexing and 2x2 piece-mask generation.
package tetris_pkg;

  localparam int MAX_CELLS = 4096;

  typedef enum logic [2:0] {
    SPAWN,
    FALL,
    LOCK,
    CLEAR,
    OVER
  } state_t;

  function automatic int cell_idx(
    input int cols,
    input int row,
    input int col
  );
    return row * cols + col;
  endfunction

  // Off-board anchors yield an empty mask.
  function automatic logic [MAX_CELLS-1:0] piece_mask(
    input int cols,
    input int rows,
    input int row,
    input int col
  );
    logic [MAX_CELLS-1:0] m;
    logic [MAX_CELLS-1:0] one;
    one = MAX_CELLS'(1);
    m = '0;
    if (row >= 0 && row < rows &&
        col >= 0 && col + 1 < cols) begin
      m = m | (one << cell_idx(cols, row, col));
      m = m | (one << cell_idx(cols, row, col + 1));
      if (row + 1 < rows) begin
        m = m | (one << cell_idx(cols, row + 1, col));
        m = m | (one << cell_idx(cols, row + 1, col + 1));
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/playfield_tick_gen.sv
// Gravity divider: counts enabled cycles, pulses tick
// on the last count of each GRAVITY_DIV period.
module playfield_tick_gen #(
  parameter int GRAVITY_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(GRAVITY_DIV);
  localparam logic [CW-1:0] LAST = CW'(GRAVITY_DIV - 1);

  logic [CW-1:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (count == LAST) count <= '0;
      else               count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tetris_playfield.sv
// Tetris board engine: one falling 2x2 piece, locking,
// row clearing with shift-down, and game-over detection.
module tetris_playfield
  import tetris_pkg::*;
#(
  parameter int COLS        = 16,
  parameter int ROWS        = 16,
  parameter int GRAVITY_DIV = 25_000_000,
  parameter int LINES_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 move_left,
  input  logic                 move_right,
  input  logic                 drop,
  output logic [COLS*ROWS-1:0] grid_out,
  output logic [LINES_W-1:0]   lines_cleared,
  output logic                 game_over,
  output logic                 busy
);

  localparam int N  = COLS * ROWS;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [CW-1:0] SPAWN_COL = CW'(COLS / 2 - 1);

  state_t          state;
  logic [N-1:0]    board;
  logic [N-1:0]    board_shift;
  logic [RW-1:0]   prow;
  logic [CW-1:0]   pcol;
  logic [RW-1:0]   scan_r;

  logic [N-1:0]    pmask;
  logic [N-1:0]    spawn_mask;
  logic [N-1:0]    down_mask;
  logic [N-1:0]    left_mask;
  logic [N-1:0]    right_mask;

  logic            in_fall;
  logic            grav_tick;
  logic            tick_any;
  logic            cnt_clr;
  logic            down_ok;
  logic            left_ok;
  logic            right_ok;
  logic            spawn_hit;
  logic            row_full;

  assign in_fall  = (state == FALL);
  assign tick_any = in_fall && (grav_tick || drop);
  assign cnt_clr  = (state == SPAWN) || tick_any;

  playfield_tick_gen #(
    .GRAVITY_DIV(GRAVITY_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .en   (in_fall),
    .clr  (cnt_clr),
    .tick (grav_tick)
  );

  assign pmask = N'(piece_mask(COLS, ROWS,
    int'(prow), int'(pcol)));
  assign spawn_mask = N'(piece_mask(COLS, ROWS,
    0, COLS / 2 - 1));
  assign down_mask = N'(piece_mask(COLS, ROWS,
    int'(prow) + 1, int'(pcol)));
  assign left_mask = N'(piece_mask(COLS, ROWS,
    int'(pcol) == 0 ? 0 : int'(prow),
    int'(pcol) - 1));
  assign right_mask = N'(piece_mask(COLS, ROWS,
    int'(prow), int'(pcol) + 1));

  assign down_ok = (int'(prow) + 2 < ROWS) &&
                   ((down_mask & board) == '0);
  assign left_ok = (pcol != '0) &&
                   ((left_mask & board) == '0);
  assign right_ok = (int'(pcol) + 2 < COLS) &&
                    ((right_mask & board) == '0);
  assign spawn_hit = (spawn_mask & board) != '0;

  assign row_full = &board[int'(scan_r) * COLS +: COLS];

  // Rows 0..scan_r move down one, row 0 empties.
  always_comb begin
    board_shift = board;
    for (int i = 0; i < ROWS; i++) begin
      if (i <= int'(scan_r)) begin
        if (i == 0)
          board_shift[0 +: COLS] = '0;
        else
          board_shift[i * COLS +: COLS] =
            board[(i - 1) * COLS +: COLS];
      end
    end
  end

  assign grid_out = board | (in_fall ? pmask : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= SPAWN;
      board         <= '0;
      prow          <= '0;
      pcol          <= '0;
      scan_r        <= '0;
      lines_cleared <= '0;
      game_over     <= 1'b0;
      busy          <= 1'b1;
    end else begin
      unique case (state)
        SPAWN: begin
          prow <= '0;
          pcol <= SPAWN_COL;
          busy <= 1'b0;
          if (spawn_hit) begin
            state     <= OVER;
            game_over <= 1'b1;
          end else begin
            state <= FALL;
          end
        end
        FALL: begin
          if (tick_any) begin
            if (down_ok) begin
              prow <= prow + 1'b1;
            end else begin
              state <= LOCK;
              busy  <= 1'b1;
            end
          end else if (move_left && !move_right) begin
            if (left_ok) pcol <= pcol - 1'b1;
          end else if (move_right && !move_left) begin
            if (right_ok) pcol <= pcol + 1'b1;
          end
        end
        LOCK: begin
          board  <= board | pmask;
          scan_r <= RW'(ROWS - 1);
          state  <= CLEAR;
        end
        CLEAR: begin
          if (row_full) begin
            board         <= board_shift;
            lines_cleared <= lines_cleared + 1'b1;
          end else if (scan_r != '0) begin
            scan_r <= scan_r - 1'b1;
          end else begin
            state <= SPAWN;
          end
        end
        OVER: begin
          game_over <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state <= SPAWN;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule
